isa_line_ctrl: RTL and testbench

Parametrised successor to the ByteBlast ISA decoder and line controller. Accepts instruction words over a valid/ready handshake, decodes opcode and operand, and drives a registered address bus with read/write strobes. Adds base-relative addressing, multi-beat bursts, halt/resume and illegal-opcode reporting. Sits between the instruction source and the line/memory interface.

---
 rtl/isa_line_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_isa_line_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/isa_line_ctrl.sv
// ---------------------------------------------------------------------------
// isa_line_ctrl
//
// Instruction decoder and line controller. Instruction words arrive over a
// valid/ready handshake, are decoded into opcode and operand, and drive a
// registered line address with read/write strobes. Supports base-relative
// reads, multi-beat read bursts, halt/resume and illegal-opcode reporting.
//
// Parameters:
//   ADDRESS_BITS - operand and line address width
//   INSTR_BITS   - opcode width (>= 3); any opcode bit above bit 2 set is illegal
//   VALUE_BITS   - derived instruction word width
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   value        - instruction word {opcode, operand}
//   value_valid  - instruction word present
//   value_ready  - block can accept a word (only while idle)
//   resume       - single-cycle pulse that leaves HALT
//   value_parity - even parity over value (only with ISA_LINE_CTRL_PARITY_EN)
//   o_address    - registered line address
//   o_rd         - read strobe, one cycle per beat
//   o_wr         - write strobe, one cycle
//   o_halted     - high while halted
//   o_err        - one-cycle pulse on illegal opcode or parity error
//
// Build option:
//   ISA_LINE_CTRL_PARITY_EN - when defined, adds value_parity and drops any
//   accepted word whose parity does not match, pulsing o_err instead.
// ---------------------------------------------------------------------------
module isa_line_ctrl #(
  parameter int ADDRESS_BITS = 5,
  parameter int INSTR_BITS   = 3,
  localparam int VALUE_BITS  = ADDRESS_BITS + INSTR_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [VALUE_BITS-1:0]   value,
  input  logic                    value_valid,
`ifdef ISA_LINE_CTRL_PARITY_EN
  input  logic                    value_parity,
`endif
  output logic                    value_ready,
  input  logic                    resume,
  output logic [ADDRESS_BITS-1:0] o_address,
  output logic                    o_rd,
  output logic                    o_wr,
  output logic                    o_halted,
  output logic                    o_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_BURST = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_READ     = 3'd1;
  localparam logic [2:0] OP_WRITE    = 3'd2;
  localparam logic [2:0] OP_SETBASE  = 3'd3;
  localparam logic [2:0] OP_READ_REL = 3'd4;
  localparam logic [2:0] OP_BURST    = 3'd5;
  localparam logic [2:0] OP_HALT     = 3'd6;

  localparam logic [ADDRESS_BITS-1:0] ADDR_ONE = {{(ADDRESS_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDRESS_BITS:0]   BEAT_ONE = {{ADDRESS_BITS{1'b0}}, 1'b1};

  state_t                  r_state;
  logic [ADDRESS_BITS-1:0] r_base;
  logic [ADDRESS_BITS:0]   r_beat;
  logic                    r_live;

  state_t                  w_state_nxt;
  logic [ADDRESS_BITS-1:0] w_base_nxt;
  logic [ADDRESS_BITS:0]   w_beat_nxt;
  logic [ADDRESS_BITS-1:0] w_address_nxt;
  logic                    w_rd_nxt;
  logic                    w_wr_nxt;
  logic                    w_halted_nxt;
  logic                    w_err_nxt;

  logic [INSTR_BITS-1:0]   w_opcode;
  logic [ADDRESS_BITS-1:0] w_operand;
  logic [2:0]              w_op;
  logic                    w_high_nz;
  logic                    w_parity_bad;
  logic                    w_accept;

  assign w_opcode  = value[VALUE_BITS-1:ADDRESS_BITS];
  assign w_operand = value[ADDRESS_BITS-1:0];
  assign w_op      = w_opcode[2:0];

  // Opcode bits above the 3-bit field only exist for wide opcodes; any of
  // them set makes the word illegal.
  generate
    if (INSTR_BITS > 3) begin : g_wide_opcode
      assign w_high_nz = |w_opcode[INSTR_BITS-1:3];
    end else begin : g_narrow_opcode
      assign w_high_nz = 1'b0;
    end
  endgenerate

`ifdef ISA_LINE_CTRL_PARITY_EN
  // Even parity: the parity bit must equal the XOR of all word bits.
  assign w_parity_bad = (^value) ^ value_parity;
`else
  assign w_parity_bad = 1'b0;
`endif

  // r_live keeps value_ready low while reset is held and for no longer,
  // without routing rst_n into combinational logic.
  assign value_ready = r_live && (r_state == S_IDLE);
  assign w_accept    = value_valid && value_ready;

  // Next-state and next-output decode. Strobes default low so every cycle
  // not explicitly listed below deasserts them; address and base hold.
  always_comb begin
    w_state_nxt   = r_state;
    w_base_nxt    = r_base;
    w_beat_nxt    = r_beat;
    w_address_nxt = o_address;
    w_rd_nxt      = 1'b0;
    w_wr_nxt      = 1'b0;
    w_halted_nxt  = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_EXEC;
          if (w_high_nz || w_parity_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            case (w_op)
              OP_NOP: ;
              OP_READ: begin
                w_address_nxt = w_operand;
                w_rd_nxt      = 1'b1;
              end
              OP_WRITE: begin
                w_address_nxt = w_operand;
                w_wr_nxt      = 1'b1;
              end
              OP_SETBASE: begin
                w_base_nxt = w_operand;
              end
              OP_READ_REL: begin
                w_address_nxt = r_base + w_operand;
                w_rd_nxt      = 1'b1;
              end
              OP_BURST: begin
                // Beat 0 goes out immediately; r_beat counts beats still
                // on the bus including the current one (1..2^ADDRESS_BITS).
                w_address_nxt = r_base;
                w_rd_nxt      = 1'b1;
                w_beat_nxt    = {1'b0, w_operand} + BEAT_ONE;
                w_state_nxt   = S_BURST;
              end
              OP_HALT: begin
                w_halted_nxt = 1'b1;
                w_state_nxt  = S_HALT;
              end
              default: begin
                w_err_nxt = 1'b1;
              end
            endcase
          end
        end
      end

      S_EXEC: begin
        w_state_nxt = S_IDLE;
      end

      S_BURST: begin
        if (r_beat == BEAT_ONE) begin
          // Last beat is on the bus now, so the new base is one past it,
          // which equals base + operand + 1 with natural wrap.
          w_base_nxt  = o_address + ADDR_ONE;
          w_beat_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_beat_nxt    = r_beat - BEAT_ONE;
          w_address_nxt = o_address + ADDR_ONE;
          w_rd_nxt      = 1'b1;
        end
      end

      S_HALT: begin
        if (resume) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_halted_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any burst immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_beat    <= '0;
      r_live    <= 1'b0;
      o_address <= '0;
      o_rd      <= 1'b0;
      o_wr      <= 1'b0;
      o_halted  <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_base    <= w_base_nxt;
      r_beat    <= w_beat_nxt;
      r_live    <= 1'b1;
      o_address <= w_address_nxt;
      o_rd      <= w_rd_nxt;
      o_wr      <= w_wr_nxt;
      o_halted  <= w_halted_nxt;
      o_err     <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_isa_line_ctrl.sv
// ---------------------------------------------------------------------------
// tb_isa_line_ctrl
//
// Directed bench for isa_line_ctrl. A small reference model pushes the
// expected per-cycle outputs into a queue as each instruction is driven;
// the queue is drained cycle by cycle against the DUT outputs. A second
// instance with a 4-bit opcode covers the wide-opcode illegal case.
// ---------------------------------------------------------------------------
module tb_isa_line_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] value;
  logic       value_valid;
  logic       value_ready;
  logic       resume;
  logic [4:0] o_address;
  logic       o_rd, o_wr, o_halted, o_err;

  logic [8:0] value4;
  logic       valid4;
  logic       ready4;
  logic       resume4;
  logic [4:0] addr4;
  logic       rd4, wr4, halted4, err4;

  isa_line_ctrl #(.ADDRESS_BITS(5), .INSTR_BITS(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
    .value_ready(value_ready), .resume(resume), .o_address(o_address),
    .o_rd(o_rd), .o_wr(o_wr), .o_halted(o_halted), .o_err(o_err)
  );

  isa_line_ctrl #(.ADDRESS_BITS(5), .INSTR_BITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .value(value4), .value_valid(valid4),
    .value_ready(ready4), .resume(resume4), .o_address(addr4),
    .o_rd(rd4), .o_wr(wr4), .o_halted(halted4), .o_err(err4)
  );

  typedef struct packed {
    logic [4:0] addr;
    logic       rd;
    logic       wr;
    logic       halted;
    logic       err;
    logic       ready;
  } obs_t;

  obs_t       expQ[$];
  int         nTotal = 0;
  int         nBad = 0;
  logic [4:0] mBase = '0;
  logic [4:0] mAddr = '0;

  // Global bound so a stuck handshake can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExp(input logic [4:0] a, input logic rd, input logic wr,
                         input logic h, input logic e, input logic rdy);
    obs_t x;
    x = {a, rd, wr, h, e, rdy};
    expQ.push_back(x);
  endtask

  task automatic compareEntry(input string tag, input obs_t obs, input obs_t exp);
    nTotal++;
    assert (obs === exp) else begin
      nBad++;
      $error("[TB] FAIL %s: observed addr=%0d rd=%b wr=%b halted=%b err=%b ready=%b, expected addr=%0d rd=%b wr=%b halted=%b err=%b ready=%b",
             tag, obs.addr, obs.rd, obs.wr, obs.halted, obs.err, obs.ready,
             exp.addr, exp.rd, exp.wr, exp.halted, exp.err, exp.ready);
    end
  endtask

  // Drain the scoreboard, one entry per cycle sampled on the falling edge.
  task automatic checkOutput(input string tag, input bit waitEdge = 1'b1,
                             input bit onDut4 = 1'b0);
    obs_t e;
    obs_t o;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (waitEdge) @(negedge clk);
      if (onDut4) o = {addr4, rd4, wr4, halted4, err4, ready4};
      else        o = {o_address, o_rd, o_wr, o_halted, o_err, value_ready};
      compareEntry(tag, o, e);
    end
  endtask

  // Reference model: expected outputs for each cycle after acceptance.
  task automatic modelPush(input logic [2:0] op, input logic [4:0] opnd);
    case (op)
      3'd0: pushExp(mAddr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      3'd1: begin mAddr = opnd; pushExp(mAddr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); end
      3'd2: begin mAddr = opnd; pushExp(mAddr, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); end
      3'd3: begin mBase = opnd; pushExp(mAddr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); end
      3'd4: begin mAddr = mBase + opnd; pushExp(mAddr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); end
      3'd5: begin
        for (int i = 0; i <= int'(opnd); i++) begin
          mAddr = mBase + 5'(i);
          pushExp(mAddr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        mBase = mBase + opnd + 5'd1;
      end
      3'd6: pushExp(mAddr, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      default: pushExp(mAddr, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endcase
    if (op != 3'd6) pushExp(mAddr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Called on a falling edge: present the word, wait (bounded) for ready,
  // let the next rising edge accept it, then drop valid.
  task automatic applyStimulus(input logic [2:0] op, input logic [4:0] opnd,
                               input bit doModel = 1'b1);
    int waited;
    waited = 0;
    value = {op, opnd};
    value_valid = 1'b1;
    while (value_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    nTotal++;
    assert (value_ready === 1'b1) else begin
      nBad++;
      $error("[TB] FAIL accept wait op=%0d: observed ready=%b, expected ready=1", op, value_ready);
    end
    @(posedge clk);
    #1 value_valid = 1'b0;
    if (doModel) modelPush(op, opnd);
  endtask

  task automatic sendDut4(input logic [8:0] w);
    int waited;
    waited = 0;
    value4 = w;
    valid4 = 1'b1;
    while (ready4 !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    nTotal++;
    assert (ready4 === 1'b1) else begin
      nBad++;
      $error("[TB] FAIL dut4 accept wait: observed ready=%b, expected ready=1", ready4);
    end
    @(posedge clk);
    #1 valid4 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; value = '0; value_valid = 1'b0; resume = 1'b0;
    value4 = '0; valid4 = 1'b0; resume4 = 1'b0;

    // Reset state, held across an edge.
    @(negedge clk);
    pushExp(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); checkOutput("reset", 1'b0);
    @(negedge clk);
    pushExp(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); checkOutput("reset hold", 1'b0);
    rst_n = 1'b1;
    pushExp(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); checkOutput("post release");

    // Single-beat operations.
    applyStimulus(3'd1, 5'd5);   checkOutput("read 5");
    applyStimulus(3'd2, 5'd17);  checkOutput("write 17");
    applyStimulus(3'd0, 5'd9);   checkOutput("nop");
    applyStimulus(3'd3, 5'd30);  checkOutput("setbase 30");
    applyStimulus(3'd4, 5'd4);   checkOutput("read_rel wrap");

    // Burst and base advance.
    applyStimulus(3'd3, 5'd3);   checkOutput("setbase 3");
    applyStimulus(3'd5, 5'd3);   checkOutput("burst 3");
    applyStimulus(3'd4, 5'd0);   checkOutput("read_rel after burst");

    // Illegal opcode.
    applyStimulus(3'd7, 5'd1);   checkOutput("illegal 7");

    // Halt with a pending write held on the bus.
    applyStimulus(3'd6, 5'd0);   checkOutput("halt entry");
    value = {3'd2, 5'd9};
    value_valid = 1'b1;
    repeat (10) pushExp(mAddr, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("halt hold");
    resume = 1'b1;
    @(posedge clk);
    #1 resume = 1'b0;
    pushExp(mAddr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); checkOutput("resume");
    applyStimulus(3'd2, 5'd9);   checkOutput("write after resume");

    // Resume while idle has no effect.
    resume = 1'b1;
    @(posedge clk);
    #1 resume = 1'b0;
    pushExp(mAddr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); checkOutput("resume idle");

    // Burst wrapping through the top of the address space.
    applyStimulus(3'd3, 5'd30);  checkOutput("setbase 30 b");
    applyStimulus(3'd5, 5'd3);   checkOutput("burst wrap");
    applyStimulus(3'd4, 5'd1);   checkOutput("read_rel after wrap");

    // Reset during a long burst.
    applyStimulus(3'd3, 5'd5);   checkOutput("setbase 5");
    applyStimulus(3'd5, 5'd31, 1'b0);
    pushExp(5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pushExp(5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort beats");
    @(posedge clk);
    #1;
    pushExp(5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); checkOutput("abort beat 2", 1'b0);
    #1 rst_n = 1'b0;
    #1;
    pushExp(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); checkOutput("abort reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mBase = '0;
    mAddr = '0;
    pushExp(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); checkOutput("abort release");
    applyStimulus(3'd4, 5'd3);   checkOutput("base cleared");

    // Wide opcode instance: legal read, then opcode 0 with the top bit set.
    sendDut4({4'b0001, 5'd3});
    pushExp(5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pushExp(5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("dut4 read", 1'b1, 1'b1);
    sendDut4({4'b1000, 5'd12});
    pushExp(5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pushExp(5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("dut4 illegal high", 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
